fifo_arbiter_mux: RTL and testbench

Merges `num_ports` independent FIFO streams, presented as breakout arrays (`ready`/`enable`/`data` per port), into one tagged output stream. Each input has a 2-entry buffer, and a round-robin arbiter grants bursts of up to `burst_len` words. The merged output goes to a registered output stage that carries the source channel number. It sits between the per-channel converter FIFOs and the single host-bound FIFO.

---
 rtl/fifo_arbiter_mux.sv | 140 ++++++++++++++
 tb/tb_fifo_arbiter_mux.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter_mux.sv
// fifo_arbiter_mux: merges num_ports 2-deep input FIFOs into one tagged stream
// through a round-robin burst arbiter and a registered output stage.
module fifo_arbiter_mux #(
    parameter int width     = 8,
    parameter int num_ports = 4,
    parameter int burst_len = 4,
    parameter int ch_width  = $clog2(num_ports)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                in_ready  [num_ports],
    input  logic                in_enable [num_ports],
    input  logic [width-1:0]    in_data   [num_ports],
    input  logic                out_ready,
    output logic                out_enable,
    output logic [width-1:0]    out_data,
    output logic [ch_width-1:0] out_channel,
    output logic                out_last
);
    localparam int bc_width = $clog2(burst_len + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state;
    logic [ch_width-1:0] last_grant;
    logic [bc_width-1:0] burst_cnt;

    logic [width-1:0] mem    [num_ports][2];
    logic             rd_ptr [num_ports];
    logic             wr_ptr [num_ports];
    logic [1:0]       count  [num_ports];
    logic             push   [num_ports];
    logic             pop    [num_ports];

    logic                can_load;
    logic                found;
    logic                pop_any;
    logic                end_grant;
    logic [ch_width-1:0] cand;
    logic [ch_width-1:0] sel;
    logic [bc_width-1:0] burst_next;

    // The end-of-grant test looks only at the pre-pop count, so a same-cycle
    // push into the granted port does not extend the burst.
    always_comb begin
        can_load   = !out_enable || out_ready;
        found      = 1'b0;
        cand       = '0;
        sel        = last_grant;
        pop_any    = 1'b0;
        burst_next = burst_cnt;
        if (state == IDLE) begin
            for (int k = 1; k <= num_ports; k++) begin
                cand = ch_width'((int'(last_grant) + k) % num_ports);
                if (!found && count[cand] != 2'd0) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
            pop_any    = can_load && found;
            burst_next = bc_width'(1);
        end else begin
            pop_any    = can_load && (count[last_grant] != 2'd0);
            burst_next = burst_cnt + bc_width'(1);
        end
        end_grant = pop_any &&
                    ((burst_next == bc_width'(burst_len)) || (count[sel] == 2'd1));
    end

    always_comb begin
        for (int i = 0; i < num_ports; i++) begin
            in_ready[i] = !reset && (count[i] < 2'd2);
            push[i]     = in_enable[i] && in_ready[i];
            pop[i]      = pop_any && (sel == ch_width'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < num_ports; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_ports; i++) begin
                rd_ptr[i] <= 1'b0;
                wr_ptr[i] <= 1'b0;
                count[i]  <= 2'd0;
            end
        end else begin
            for (int i = 0; i < num_ports; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= !wr_ptr[i];
                end
                if (pop[i]) begin
                    rd_ptr[i] <= !rd_ptr[i];
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 2'd1;
                    2'b01:   count[i] <= count[i] - 2'd1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Arbiter state and output register share one block so that a grant ending
    // on the loaded word drops straight back to IDLE for the next loadable cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= ch_width'(num_ports - 1);
            burst_cnt   <= '0;
            out_enable  <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_last    <= 1'b0;
        end else begin
            if (can_load) begin
                out_enable <= pop_any;
                if (pop_any) begin
                    out_data    <= mem[sel][rd_ptr[sel]];
                    out_channel <= sel;
                    out_last    <= end_grant;
                end
            end
            if (pop_any) begin
                last_grant <= sel;
                burst_cnt  <= burst_next;
                state      <= end_grant ? IDLE : GRANT;
            end
        end
    end
endmodule

// File: tb/tb_fifo_arbiter_mux.sv
// tb_fifo_arbiter_mux: directed, self-checking bench for fifo_arbiter_mux
// with hand-derived expectations and a transfer log for stream-level checks.
module tb_fifo_arbiter_mux;
    localparam int width     = 8;
    localparam int num_ports = 4;
    localparam int burst_len = 4;
    localparam int ch_width  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_ready  [num_ports];
    logic                in_enable [num_ports];
    logic [width-1:0]    in_data   [num_ports];
    logic                out_ready;
    logic                out_enable;
    logic [width-1:0]    out_data;
    logic [ch_width-1:0] out_channel;
    logic                out_last;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    bit accepted [num_ports];
    bit auto_src [num_ports];
    int src_seq  [num_ports];

    int log_ch[$];
    int log_data[$];
    int log_last[$];
    int log_cyc[$];

    fifo_arbiter_mux #(
        .width    (width),
        .num_ports(num_ports),
        .burst_len(burst_len),
        .ch_width (ch_width)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_ready   (in_ready),
        .in_enable  (in_enable),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_enable (out_enable),
        .out_data   (out_data),
        .out_channel(out_channel),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Backlogged sources emit port*64 + sequence so every word names its origin.
    function automatic logic [width-1:0] src_word(int p, int s);
        return 8'(p * 64 + (s % 64));
    endfunction

    task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then advance sources.
    task automatic apply_stimulus();
        @(negedge clk);
        for (int i = 0; i < num_ports; i++) begin
            accepted[i] = in_enable[i] && in_ready[i];
        end
        if (out_enable && out_ready) begin
            log_ch.push_back(int'(out_channel));
            log_data.push_back(int'(out_data));
            log_last.push_back(int'(out_last));
            log_cyc.push_back(cycle);
        end
        @(posedge clk);
        cycle++;
        #1;
        for (int i = 0; i < num_ports; i++) begin
            if (accepted[i]) begin
                src_seq[i]++;
            end
            if (auto_src[i]) begin
                in_enable[i] = 1'b1;
                in_data[i]   = src_word(i, src_seq[i]);
            end
        end
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus();
        end
    endtask

    task automatic set_auto(int p, bit on);
        auto_src[p]  = on;
        in_enable[p] = on;
        in_data[p]   = src_word(p, src_seq[p]);
    endtask

    task automatic clear_log();
        log_ch.delete();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < num_ports; i++) begin
            auto_src[i]  = 1'b0;
            in_enable[i] = 1'b0;
            in_data[i]   = '0;
            src_seq[i]   = 0;
        end
        run_cycles(2);
        reset = 1'b0;
        clear_log();
    endtask

    // Each channel's words must leave in the order its source produced them.
    function automatic int data_order_errors();
        int exp_seq [num_ports];
        int bad = 0;
        for (int i = 0; i < num_ports; i++) exp_seq[i] = 0;
        for (int j = 0; j < log_data.size(); j++) begin
            if (log_data[j] != int'(src_word(log_ch[j], exp_seq[log_ch[j]]))) bad++;
            exp_seq[log_ch[j]]++;
        end
        return bad;
    endfunction

    function automatic int gap_count();
        int bad = 0;
        for (int j = 1; j < log_cyc.size(); j++) begin
            if (log_cyc[j] != log_cyc[j-1] + 1) bad++;
        end
        return bad;
    endfunction

    initial begin
        int start;
        int bad;
        int per_ch [num_ports];
        int n;

        reset     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < num_ports; i++) begin
            in_enable[i] = 1'b0;
            in_data[i]   = '0;
            auto_src[i]  = 1'b0;
            src_seq[i]   = 0;
        end
        #1;

        $display("[TB] reset values");
        reset = 1'b1;
        #1;
        check_output("rst_out_enable", 32'(out_enable), 0);
        check_output("rst_out_data", 32'(out_data), 0);
        check_output("rst_out_channel", 32'(out_channel), 0);
        check_output("rst_out_last", 32'(out_last), 0);
        for (int i = 0; i < num_ports; i++) check_output("rst_in_ready", 32'(in_ready[i]), 0);
        run_cycles(2);
        reset = 1'b0;
        #1;
        for (int i = 0; i < num_ports; i++) check_output("post_rst_in_ready", 32'(in_ready[i]), 1);

        $display("[TB] single word latency");
        do_reset();
        out_ready    = 1'b1;
        in_enable[2] = 1'b1;
        in_data[2]   = 8'hA5;
        apply_stimulus();
        in_enable[2] = 1'b0;
        check_output("lat_k_out_enable", 32'(out_enable), 0);
        apply_stimulus();
        check_output("lat_k1_out_enable", 32'(out_enable), 1);
        check_output("lat_k1_out_data", 32'(out_data), 32'hA5);
        check_output("lat_k1_out_channel", 32'(out_channel), 2);
        check_output("lat_k1_out_last", 32'(out_last), 1);
        apply_stimulus();
        check_output("lat_k2_out_enable", 32'(out_enable), 0);

        $display("[TB] round robin, out_ready held high");
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < num_ports; i++) set_auto(i, 1'b1);
        run_cycles(48);
        start = 0;
        while (start < log_last.size() && log_last[start] == 0) start++;
        start++;
        check_output("rr_log_size", 32'(log_ch.size() >= start + 33), 1);
        bad = 0;
        for (int j = start; j + 1 < log_ch.size(); j++) begin
            if (log_last[j] == 1 && log_ch[j+1] != (log_ch[j] + 1) % num_ports) bad++;
            if (log_last[j] == 0 && log_ch[j+1] != log_ch[j]) bad++;
        end
        check_output("rr_order", 32'(bad), 0);
        check_output("rr_data_order", 32'(data_order_errors()), 0);
        check_output("rr_bubbles", 32'(gap_count()), 0);
        for (int i = 0; i < num_ports; i++) per_ch[i] = 0;
        for (int j = start; j < start + 32 && j < log_ch.size(); j++) per_ch[log_ch[j]]++;
        for (int i = 0; i < num_ports; i++) check_output("rr_fairness", 32'(per_ch[i]), 8);

        $display("[TB] burst cap with alternating out_ready");
        do_reset();
        for (int i = 0; i < num_ports; i++) set_auto(i, 1'b1);
        run_cycles(6);
        for (int s = 0; s < 50; s++) begin
            out_ready = (s % 2 == 0);
            apply_stimulus();
        end
        // First word is port 0's lone pre-loaded word, then full 4-word bursts from port 1 on.
        check_output("cap_log_size", 32'(log_ch.size() >= 21), 1);
        n = (log_ch.size() < 21) ? log_ch.size() : 21;
        for (int j = 0; j < n; j++) begin
            check_output("cap_channel", 32'(log_ch[j]), (j == 0) ? 0 : 32'(((j - 1) / 4 + 1) % num_ports));
            check_output("cap_last", 32'(log_last[j]), (j == 0 || j % 4 == 0) ? 1 : 0);
        end
        check_output("cap_data_order", 32'(data_order_errors()), 0);

        $display("[TB] backpressure");
        do_reset();
        set_auto(1, 1'b1);
        run_cycles(3);
        check_output("bp_hold_data_early", 32'(out_data), 32'h40);
        run_cycles(7);
        check_output("bp_in_ready", 32'(in_ready[1]), 0);
        check_output("bp_accepted", 32'(src_seq[1]), 3);
        check_output("bp_out_enable", 32'(out_enable), 1);
        check_output("bp_hold_data_late", 32'(out_data), 32'h40);
        check_output("bp_hold_channel", 32'(out_channel), 1);
        set_auto(1, 1'b0);
        out_ready = 1'b1;
        run_cycles(5);
        check_output("bp_drain_size", 32'(log_data.size()), 3);
        if (log_data.size() == 3) begin
            check_output("bp_drain_w0", 32'(log_data[0]), 32'h40);
            check_output("bp_drain_w1", 32'(log_data[1]), 32'h41);
            check_output("bp_drain_w2", 32'(log_data[2]), 32'h42);
            check_output("bp_drain_last0", 32'(log_last[0]), 1);
            check_output("bp_drain_last1", 32'(log_last[1]), 0);
            check_output("bp_drain_last2", 32'(log_last[2]), 1);
            check_output("bp_drain_ch", 32'(log_ch[1]), 1);
        end

        $display("[TB] short burst");
        do_reset();
        in_enable[2] = 1'b1;
        in_data[2]   = 8'h2A;
        apply_stimulus();
        in_enable[2] = 1'b0;
        in_enable[3] = 1'b1;
        in_data[3]   = 8'hC0;
        apply_stimulus();
        in_data[3]   = 8'hC1;
        apply_stimulus();
        in_enable[3] = 1'b0;
        set_auto(0, 1'b1);
        run_cycles(3);
        out_ready = 1'b1;
        run_cycles(8);
        check_output("sb_log_size", 32'(log_ch.size() >= 5), 1);
        if (log_ch.size() >= 5) begin
            check_output("sb_w0_data", 32'(log_data[0]), 32'h2A);
            check_output("sb_w1_ch", 32'(log_ch[1]), 3);
            check_output("sb_w1_data", 32'(log_data[1]), 32'hC0);
            check_output("sb_w1_last", 32'(log_last[1]), 0);
            check_output("sb_w2_ch", 32'(log_ch[2]), 3);
            check_output("sb_w2_data", 32'(log_data[2]), 32'hC1);
            check_output("sb_w2_last", 32'(log_last[2]), 1);
            check_output("sb_w3_ch", 32'(log_ch[3]), 0);
            check_output("sb_w3_data", 32'(log_data[3]), 32'h00);
            check_output("sb_w4_data", 32'(log_data[4]), 32'h01);
            check_output("sb_no_gap", 32'(log_cyc[3] - log_cyc[2]), 1);
        end

        $display("[TB] rejected enable");
        do_reset();
        in_enable[0] = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            in_data[0] = 8'(w);
            apply_stimulus();
        end
        check_output("rej_in_ready", 32'(in_ready[0]), 0);
        in_data[0] = 8'h77;
        run_cycles(3);
        in_enable[0] = 1'b0;
        check_output("rej_accepted", 32'(src_seq[0]), 3);
        out_ready = 1'b1;
        run_cycles(6);
        check_output("rej_drain_size", 32'(log_data.size()), 3);
        bad = 0;
        for (int j = 0; j < log_data.size(); j++) begin
            if (log_data[j] != j + 1) bad++;
        end
        check_output("rej_drain_words", 32'(bad), 0);

        $display("[TB] reset mid-stream");
        do_reset();
        for (int i = 0; i < num_ports; i++) set_auto(i, 1'b1);
        run_cycles(5);
        check_output("mid_pre_out_enable", 32'(out_enable), 1);
        check_output("mid_pre_in_ready0", 32'(in_ready[1]), 0);
        #2;
        reset = 1'b1;
        #1;
        check_output("mid_out_enable", 32'(out_enable), 0);
        check_output("mid_out_data", 32'(out_data), 0);
        check_output("mid_out_last", 32'(out_last), 0);
        for (int i = 0; i < num_ports; i++) check_output("mid_in_ready", 32'(in_ready[i]), 0);
        for (int i = 0; i < num_ports; i++) set_auto(i, 1'b0);
        run_cycles(2);
        check_output("mid_held_in_ready", 32'(in_ready[0]), 0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < num_ports; i++) check_output("mid_release_in_ready", 32'(in_ready[i]), 1);
        clear_log();
        out_ready = 1'b1;
        run_cycles(6);
        check_output("mid_no_stale", 32'(log_data.size()), 0);
        check_output("mid_out_idle", 32'(out_enable), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
